// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter state encoding (ARB_IDLE / ARB_XFER)
//   MAX_REQ     : largest supported requester count
//   clog2_req   : width of a requester index / round-robin pointer
// No ports (package).
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 16;

  // Index width for n requesters; never below 1 so a 2-requester build
  // still gets a usable pointer. The loop bound covers MAX_REQ.
  function automatic int clog2_req(input int n);
    int w;
    w = 1;
    for (int k = 0; k < 5; k++) begin
      if ((32'sd1 << w) < n) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester streams and the transmitter handshake of the arbiter.
//   i_req_valid/i_req_data/i_req_last : requester byte streams (byte k at [8k+7:8k])
//   o_req_ready                       : per-requester accept strobe
//   o_wr/o_data                       : to the transmitter's i_wr/i_data
//   i_busy                            : from the transmitter's o_busy
//   o_grant                           : one-hot current owner
//   o_timeout                         : watchdog revoke pulse
// Modports: slave = arbiter side, master = requesters/transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 o_wr;
  logic [7:0]           o_data;
  logic                 i_busy;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_busy,
    output o_req_ready, o_wr, o_data, o_grant, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_busy,
    input  o_req_ready, o_wr, o_data, o_grant, o_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: first set request bit strictly after
// i_ptr, wrapping modulo NUM_REQ (i_ptr itself is checked last).
//   i_req  : request vector
//   i_ptr  : index of the most recent owner
//   o_pick : one-hot winner (zero when no request)
//   o_idx  : index of the winner
//   o_any  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = clog2_req(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  logic [PW-1:0] w_cand;
  logic          w_found;

  // Walk candidates ptr+1, ptr+2, ... ptr (mod NUM_REQ); first hit wins.
  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = PW'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_pick[w_cand] = 1'b1;
        o_idx          = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locked arbiter sharing one wb_uart_tx between NUM_REQ
// byte-stream requesters. A grant is held until the owner's last byte is
// accepted by the transmitter, so messages never interleave.
//
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : uart_tx_arbiter_if.slave (requester streams, transmitter
//             i_wr/i_data/o_busy, grant vector, timeout pulse)
//
// Parameters:
//   NUM_REQ        : requester count, 2..MAX_REQ
//   TIMEOUT_CYCLES : mid-packet stall limit (watchdog builds only)
//
// Build option:
//   UART_TX_ARBITER_TIMEOUT_EN : when defined, a watchdog revokes a grant
//   after TIMEOUT_CYCLES cycles without an accept. When undefined no counter
//   exists, o_timeout is 0 and a stalled owner keeps the transmitter.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000
) (
  input logic              i_clk,
  input logic              i_reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int            PW      = clog2_req(NUM_REQ);
  // Pointer resets to the highest index so requester 0 is searched first.
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [PW-1:0]      r_owner;
  logic [PW-1:0]      w_owner_nxt;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;

  logic [NUM_REQ-1:0] w_pick;
  logic [PW-1:0]      w_pick_idx;
  logic               w_any;

  logic               w_xfer;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic               w_wr;
  logic               w_accept;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_ready;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req  (bus.i_req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  assign w_xfer = (r_state == ARB_XFER);

  // Select the owner's valid/last/data lanes.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == PW'(k)) begin
        w_own_valid = bus.i_req_valid[k];
        w_own_last  = bus.i_req_last[k];
        w_own_data  = bus.i_req_data[8*k +: 8];
      end else begin
        w_own_valid = w_own_valid;
      end
    end
  end

  // Write strobe follows the owner's valid directly; a gap in valid simply
  // drops o_wr and the transmitter sees nothing.
  assign w_wr     = w_xfer && w_own_valid;
  // Same condition the transmitter uses to latch a byte.
  assign w_accept = w_wr && !bus.i_busy;

  // Only the owner can be ready, and only while the transmitter is free.
  always_comb begin
    w_ready = '0;
    if (w_xfer) begin
      w_ready = r_grant & {NUM_REQ{!bus.i_busy}};
    end else begin
      w_ready = '0;
    end
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic [31:0] r_tcnt;
  logic [31:0] w_tcnt_nxt;

  // Fires in the last granted cycle; the revoke takes effect at the edge.
  assign w_timeout = w_xfer && !w_accept &&
                     (r_tcnt == (TIMEOUT_CYCLES - 32'd1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, packet lock and release in XFER.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
`endif
    case (r_state)
      ARB_IDLE: begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        w_tcnt_nxt = 32'd0;
`endif
        if (w_any) begin
          w_state_nxt = ARB_XFER;
          w_grant_nxt = w_pick;
          w_owner_nxt = w_pick_idx;
        end else begin
          w_grant_nxt = '0;
        end
      end
      ARB_XFER: begin
        if (w_accept) begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          w_tcnt_nxt = 32'd0;
`endif
          if (w_own_last) begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = r_owner;
          end else begin
            w_state_nxt = ARB_XFER;
          end
        end else if (w_timeout) begin
          // Watchdog revoke: the stalled owner goes to the back of the line.
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_owner;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          w_tcnt_nxt  = 32'd0;
`endif
        end else begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          w_tcnt_nxt  = r_tcnt + 32'd1;
`endif
          w_state_nxt = ARB_XFER;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Arbiter state, grant, owner index and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= PTR_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  // Stall counter: cycles in XFER since the last accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tcnt <= 32'd0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
    end
  end
`endif

  assign bus.o_wr        = w_wr;
  assign bus.o_data      = w_xfer ? w_own_data : 8'h00;
  assign bus.o_req_ready = w_ready;
  assign bus.o_grant     = r_grant;
  assign bus.o_timeout   = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with four requesters, a byte-queue
// driver per requester and a simple transmitter busy model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BUSY_LEN = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Requester message storage: {last, data}
  logic [8:0] mem [N][16];
  int         head [N];
  int         tail [N];
  logic [N-1:0] en;
  logic       force_busy;
  int         bcnt;
  logic [7:0] line_q [$];
  int         acc_cnt;
  int         ncyc;

  // Samples of the last cycle
  int         s_cyc;
  logic [N-1:0] s_grant;
  logic [N-1:0] s_ready;
  logic       s_wr;
  logic       s_acc;
  logic       s_to;
  logic [7:0] s_data;

  int n_vec;
  int n_err;

  // Scratch
  int a0, n, nseg, zrun, lock_viol, bad_ready, bad_data;
  int acc_at, to_at, to_cnt, grant_after;
  logic [N-1:0] prev;
  logic [N-1:0] seg_own [8];
  int           seg_gap [8];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int k, input logic last, input logic [7:0] data);
    mem[k][tail[k]] = {last, data};
    tail[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (en[k] && (head[k] < tail[k])) begin
        bus.i_req_valid[k]      = 1'b1;
        bus.i_req_data[8*k +: 8] = mem[k][head[k]][7:0];
        bus.i_req_last[k]       = mem[k][head[k]][8];
      end else begin
        bus.i_req_valid[k]      = 1'b0;
        bus.i_req_data[8*k +: 8] = 8'h00;
        bus.i_req_last[k]       = 1'b0;
      end
    end
    bus.i_busy = force_busy || (bcnt > 0);
  endtask

  // One clock: sample at negedge, advance requesters and busy model after posedge.
  task automatic cyc();
    @(negedge clk);
    s_cyc   = ncyc;
    s_grant = bus.o_grant;
    s_ready = bus.o_req_ready;
    s_wr    = bus.o_wr;
    s_data  = bus.o_data;
    s_to    = bus.o_timeout;
    s_acc   = bus.o_wr && !bus.i_busy;
    if (s_acc) begin
      line_q.push_back(bus.o_data);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (bus.i_req_valid[k] && s_ready[k]) head[k]++;
    end
    if (s_acc) bcnt = BUSY_LEN;
    else if (bcnt > 0) bcnt--;
    ncyc++;
    drive();
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    en         = '0;
    force_busy = 1'b0;
    bcnt       = 0;
    acc_cnt    = 0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    line_q.delete();
    drive();
    cyc();
    cyc();
    rst = 1'b0;
    drive();
  endtask

  task automatic wait_empty(input int k, input int max_cyc, input string tag);
    int c;
    c = 0;
    while ((head[k] < tail[k]) && (c < max_cyc)) begin
      cyc();
      c++;
    end
    check_val(tag, 32'(head[k] < tail[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    ncyc  = 0;

    // ---------------- reset state ----------------
    reset_dut();
    check_val("rst_grant", 32'(s_grant), 32'd0);
    check_val("rst_wr", 32'(s_wr), 32'd0);
    check_val("rst_ready", 32'(s_ready), 32'd0);
    check_val("rst_timeout", 32'(s_to), 32'd0);

    // ---------------- single requester "Hi" ----------------
    push(0, 1'b0, 8'h48);
    push(0, 1'b1, 8'h69);
    en[0] = 1'b1;
    drive();
    cyc();
    check_val("hi_idle_grant", 32'(s_grant), 32'd0);
    cyc();
    check_val("hi_grant", 32'(s_grant), 32'b0001);
    check_val("hi_wr", 32'(s_wr), 32'd1);
    check_val("hi_data0", 32'(s_data), 32'h48);
    check_val("hi_ready", 32'(s_ready), 32'b0001);
    wait_empty(0, 30, "hi_drain");
    cyc();
    check_val("hi_back_idle", 32'(s_grant), 32'd0);
    check_val("hi_accepts", 32'(acc_cnt), 32'd2);
    check_val("hi_line0", 32'(line_q[0]), 32'h48);
    check_val("hi_line1", 32'(line_q[1]), 32'h69);

    // ---------------- round-robin order ----------------
    reset_dut();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 4; j++) push(k, 1'b1, 8'(k));
    end
    en = 4'b1111;
    drive();
    nseg = 0;
    zrun = 0;
    prev = '0;
    for (int c = 0; (c < 300) && (nseg < 5); c++) begin
      cyc();
      if ((s_grant != 4'b0000) && (s_grant != prev)) begin
        seg_own[nseg] = s_grant;
        seg_gap[nseg] = zrun;
        nseg++;
      end
      if (s_grant == 4'b0000) zrun++;
      else zrun = 0;
      prev = s_grant;
    end
    check_val("rr_nseg", 32'(nseg), 32'd5);
    check_val("rr_own0", 32'(seg_own[0]), 32'b0001);
    check_val("rr_own1", 32'(seg_own[1]), 32'b0010);
    check_val("rr_own2", 32'(seg_own[2]), 32'b0100);
    check_val("rr_own3", 32'(seg_own[3]), 32'b1000);
    check_val("rr_own4", 32'(seg_own[4]), 32'b0001);
    for (int s = 1; s < 5; s++) check_val("rr_gap", 32'(seg_gap[s]), 32'd1);

    // ---------------- packet lock ----------------
    reset_dut();
    for (int b = 0; b < 5; b++) push(1, (b == 4), 8'(8'h10 + b));
    en[1] = 1'b1;
    drive();
    cyc();
    push(0, 1'b1, 8'hA0);
    push(2, 1'b1, 8'hC0);
    en[0] = 1'b1;
    en[2] = 1'b1;
    drive();
    lock_viol = 0;
    n = 0;
    while ((head[1] < tail[1]) && (n < 200)) begin
      cyc();
      if (s_ready[0] || s_ready[2]) lock_viol++;
      n++;
    end
    check_val("lock_others_ready", 32'(lock_viol), 32'd0);
    check_val("lock_drained", 32'(head[1]), 32'd5);
    nseg = 0;
    prev = 4'b0010;
    n = 0;
    while (((head[0] < tail[0]) || (head[2] < tail[2])) && (n < 200)) begin
      cyc();
      if ((s_grant != 4'b0000) && (s_grant != prev) && (nseg < 8)) begin
        seg_own[nseg] = s_grant;
        nseg++;
      end
      prev = s_grant;
      n++;
    end
    check_val("lock_nseg", 32'(nseg), 32'd2);
    check_val("lock_next_req2", 32'(seg_own[0]), 32'b0100);
    check_val("lock_then_req0", 32'(seg_own[1]), 32'b0001);
    check_val("lock_line_len", 32'(line_q.size()), 32'd7);
    for (int b = 0; b < 5; b++) check_val("lock_line_req1", 32'(line_q[b]), 32'(8'h10 + b));
    check_val("lock_line_req2", 32'(line_q[5]), 32'hC0);
    check_val("lock_line_req0", 32'(line_q[6]), 32'hA0);

    // ---------------- busy backpressure ----------------
    reset_dut();
    push(0, 1'b0, 8'h55);
    push(0, 1'b1, 8'h56);
    en[0]      = 1'b1;
    force_busy = 1'b1;
    drive();
    a0        = acc_cnt;
    bad_ready = 0;
    bad_data  = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (s_ready != 4'b0000) bad_ready++;
      if ((s_grant != 4'b0000) && (s_data != 8'h55)) bad_data++;
    end
    check_val("bp_ready_low", 32'(bad_ready), 32'd0);
    check_val("bp_data_stable", 32'(bad_data), 32'd0);
    check_val("bp_no_accept", 32'(acc_cnt - a0), 32'd0);
    check_val("bp_grant_held", 32'(s_grant), 32'b0001);
    force_busy = 1'b0;
    drive();
    cyc();
    check_val("bp_accept", 32'(s_acc), 32'd1);
    check_val("bp_accept_data", 32'(s_data), 32'h55);
    check_val("bp_accept_ready", 32'(s_ready), 32'b0001);
    cyc();
    check_val("bp_no_dup", 32'(s_acc), 32'd0);
    check_val("bp_one_accept", 32'(acc_cnt - a0), 32'd1);

    // ---------------- mid-message reset ----------------
    reset_dut();
    push(0, 1'b1, 8'hF0);
    push(0, 1'b0, 8'h31);
    push(0, 1'b0, 8'h32);
    push(0, 1'b0, 8'h33);
    push(0, 1'b1, 8'h34);
    en[0] = 1'b1;
    drive();
    a0 = acc_cnt;
    n  = 0;
    while (((acc_cnt - a0) < 3) && (n < 100)) begin
      cyc();
      n++;
    end
    check_val("mr_progress", 32'(acc_cnt - a0), 32'd3);
    rst   = 1'b1;
    en[1] = 1'b1;
    push(1, 1'b1, 8'hB1);
    drive();
    cyc();
    cyc();
    check_val("mr_grant_drop", 32'(s_grant), 32'd0);
    check_val("mr_wr_drop", 32'(s_wr), 32'd0);
    rst     = 1'b0;
    head[0] = 0;
    tail[0] = 0;
    push(0, 1'b1, 8'hE0);
    drive();
    cyc();
    check_val("mr_idle", 32'(s_grant), 32'd0);
    cyc();
    check_val("mr_req0_wins", 32'(s_grant), 32'b0001);

    // ---------------- timeout ----------------
    reset_dut();
    push(2, 1'b0, 8'hD2);
    push(3, 1'b1, 8'hD3);
    en[2] = 1'b1;
    en[3] = 1'b1;
    drive();
    acc_at      = -1;
    to_at       = -1;
    to_cnt      = 0;
    grant_after = -1;
    for (int c = 0; c < 60; c++) begin
      cyc();
      if (s_acc && (acc_at < 0)) acc_at = s_cyc;
      if (s_to) begin
        to_cnt++;
        if (to_at < 0) to_at = s_cyc;
      end
      if ((to_at >= 0) && (s_grant == 4'b1000) && (grant_after < 0)) grant_after = s_cyc;
    end
    check_val("to_first_accept_seen", 32'(acc_at >= 0), 32'd1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    check_val("to_pulse_count", 32'(to_cnt), 32'd1);
    check_val("to_delay", 32'(to_at - acc_at), 32'd16);
    check_val("to_next_grant", 32'(grant_after - to_at), 32'd2);
    check_val("to_req3_done", 32'(head[3]), 32'd1);
`else
    check_val("nt_no_pulse", 32'(to_cnt), 32'd0);
    check_val("nt_grant_held", 32'(s_grant), 32'b0100);
    check_val("nt_req3_waits", 32'(head[3]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter sharing one `wb_uart_tx` transmitter between `NUM_REQ` byte-stream requesters, such as a ROM-driven banner, a debug dumper, or CPU console bytes. Each requester presents valid/data/last. The block grants one requester and holds that grant until the requester's `last` byte is accepted by the UART, so messages never interleave. It drives `i_wr`/`i_data` of the transmitter directly and observes its `o_busy`.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `TIMEOUT_CYCLES`, default 2_500_000: stall limit mid-packet. Used only with the timeout feature; width is 32 bits.
- `i_clk` input, 1: system clock; all logic is on its rising edge.
- `i_reset` input, 1: synchronous, active-high reset.
- `i_req_valid` input, NUM_REQ: per-requester byte valid.
- `i_req_data` input, 8*NUM_REQ: byte of requester k at `[8k+7:8k]`.
- `i_req_last` input, NUM_REQ: the presented byte is the final byte of the message.
- `o_req_ready` output, NUM_REQ: byte accepted this cycle when valid&&ready.
- `o_wr` output, 1: to `wb_uart_tx.i_wr`.
- `o_data` output, 8: to `wb_uart_tx.i_data`.
- `i_busy` input, 1: from `wb_uart_tx.o_busy`.
- `o_grant` output, NUM_REQ: one-hot current owner; zero when idle.
- `o_timeout` output, 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- State machine with two states.
  - IDLE: `o_grant`=0, `o_wr`=0. If any `i_req_valid` bit is set, pick the first set bit searching upward from `ptr+1` with modulo wrap, register it into `o_grant`, and go to XFER.
  - XFER, owner g: `o_wr` = `i_req_valid[g]`; `o_data` = byte g, muxed combinationally; `o_req_ready[g]` = `!i_busy`. All other ready bits are 0.
- Accept is `o_wr && !i_busy`. This matches the transmitter's latch condition.
- Accept with `i_req_last[g]`: set `ptr`<=g, clear the grant, and go to IDLE.
- Owner deasserts valid mid-message: the grant is held and `o_wr` drops. The transmitter ignores the gap.
- Non-owners are never ready. Their valid bits may toggle freely and have no effect.
- A requester with a single-byte message asserts valid and last together. This is legal.
- A new request that appears while in IDLE in the same cycle as others: the round-robin order decides.

## Timing
- Reset values: state IDLE, `o_grant`=0, `o_wr`=0, `o_req_ready`=0, `o_timeout`=0. `ptr`=NUM_REQ-1, so requester 0 wins first. Timeout counter resets to 0.
- Arbitration latency: request seen in IDLE at cycle n, grant visible at n+1, first `o_wr` possible at n+1.
- Per-message overhead: exactly one IDLE cycle between the last accept and the next grant.
- `o_data`/`o_wr` are combinational from the owner's inputs. Requesters hold data stable while valid && !ready.
- Reset mid-message: the grant is dropped the next cycle and the partial message is abandoned. A byte the UART already latched still completes on the line.
- `i_busy` high when XFER is entered: `o_wr` stays asserted and waits. There is no loss and no duplicate.

## Configuration
- `UART_TX_ARBITER_TIMEOUT_EN` defined:
  - In XFER, a 32-bit counter increments on every cycle without an accept and clears on accept.
  - When the count reaches `TIMEOUT_CYCLES - 1` with no accept: revoke the grant, pulse `o_timeout` for one cycle, set `ptr`<=g, and go to IDLE.
  - The counter clears on entering IDLE.
- Undefined: no counter is built, `o_timeout` is tied 0, `TIMEOUT_CYCLES` is ignored, and a stalled owner holds the UART indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - state enum `{ARB_IDLE, ARB_XFER}`;
  - localparam `MAX_REQ`=16;
  - function `clog2_req` for the `ptr` width.
- Sub-module `rr_pick`: purely combinational round-robin priority search.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot pick and its index.
  - Parameter: NUM_REQ.

## Test plan
- **Reset, then single requester.** Reset, then req0 sends "Hi" (0x48, then 0x69 with last), `i_busy` modelled by `wb_uart_tx`. Required: grant=0001 one cycle after valid, two accepts, line shows 0x48 then 0x69, back to IDLE.
- **Round-robin order.** All four requesters request one-byte messages simultaneously and continuously. Required: grants in order 0,1,2,3,0, with exactly one IDLE cycle between grants.
- **Packet lock.** req1 sends 5 bytes while req0 stays valid throughout. Required: req0 ready stays 0 until req1's last byte is accepted. Next grant = req2 if valid, otherwise req0.
- **Busy backpressure.** Force `i_busy`=1 for 100 cycles while the owner is valid. Required: `o_req_ready`=0 and `o_data` stable; exactly one accept on the cycle after busy falls.
- **Mid-message reset.** Assert `i_reset` after the 2nd of 4 bytes. Required: `o_grant`=0 and `o_wr`=0 the next cycle, `ptr` reset so req0 wins next.
- **Timeout.** With `UART_TX_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, req2 sends one byte without last, then drops valid. Required: `o_timeout` pulses exactly 16 cycles after the last accept, then req3 is granted. Without the macro, the grant is held and `o_timeout` stays 0.
